// File: rtl/imul_arbiter_if.sv
// Handshake bundle between requesters, the imul_arbiter and the shared multiplier.
// The slave modport is the arbiter's view; the master modport is the surrounding
// environment (requesters plus multiplier).
interface imul_arbiter_if #(
  parameter int unsigned p_num_reqs   = 2,
  parameter int unsigned p_msg_nbits  = 64,
  parameter int unsigned p_resp_nbits = 32
);
  logic [p_num_reqs-1:0]             req_val;
  logic [p_num_reqs-1:0]             req_rdy;
  logic [p_num_reqs*p_msg_nbits-1:0] req_msg;
  logic [p_num_reqs-1:0]             resp_val;
  logic [p_num_reqs-1:0]             resp_rdy;
  logic [p_resp_nbits-1:0]           resp_msg;
  logic                              mul_req_val;
  logic                              mul_req_rdy;
  logic [p_msg_nbits-1:0]            mul_req_msg;
  logic                              mul_resp_val;
  logic                              mul_resp_rdy;
  logic [p_resp_nbits-1:0]           mul_resp_msg;

  modport slave (
    input  req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
    output req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
  );

  modport master (
    output req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
    input  req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
  );
endinterface

// File: rtl/imul_arbiter.sv
// imul_arbiter: round-robin sharing of one iterative multiplier among p_num_reqs
// requesters, with at most one multiplication in flight. The owner of the
// outstanding operation is remembered so the product is routed back to it.
// Optional feature macro: IMUL_ARBITER_BYPASS_EN -- when defined, a new request
// may be granted in the same cycle the previous response fires (0-cycle gap).
module imul_arbiter #(
  parameter int unsigned p_num_reqs   = 2,
  parameter int unsigned p_msg_nbits  = 64,
  parameter int unsigned p_resp_nbits = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  imul_arbiter_if.slave                 bus,
  output logic [$clog2(p_num_reqs)-1:0] owner,
  output logic                          busy,
  output logic [7:0]                    num_xacts
);

  localparam int unsigned IW  = $clog2(p_num_reqs);
  localparam int unsigned IW1 = IW + 1;

`ifdef IMUL_ARBITER_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [IW-1:0]   grant;
  logic            any_val;
  logic [IW1-1:0]  scan_idx;
  logic            arb_en;
  logic            req_fire;
  logic            resp_fire;

  logic [p_msg_nbits-1:0] msg_arr [p_num_reqs];

  for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_unpack
    assign msg_arr[gi] = bus.req_msg[gi*p_msg_nbits +: p_msg_nbits];
  end

  // Round-robin pick: first valid requester at or after the registered pointer.
  always_comb begin
    grant    = ptr_q;
    any_val  = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      scan_idx = {1'b0, ptr_q} + IW1'(i);
      if (scan_idx >= IW1'(p_num_reqs)) begin
        scan_idx = scan_idx - IW1'(p_num_reqs);
      end
      if (!any_val && bus.req_val[scan_idx[IW-1:0]]) begin
        any_val = 1'b1;
        grant   = scan_idx[IW-1:0];
      end
    end
  end

  // FSM next state and handshake outputs; everything reads 0 while reset is low.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    owner_d          = owner_q;
    cnt_d            = cnt_q;
    bus.req_rdy      = '0;
    bus.resp_val     = '0;
    bus.resp_msg     = '0;
    bus.mul_req_val  = 1'b0;
    bus.mul_req_msg  = '0;
    bus.mul_resp_rdy = 1'b0;
    arb_en           = 1'b0;
    req_fire         = 1'b0;
    resp_fire        = 1'b0;

    if (reset) begin
      case (state_q)
        S_IDLE: arb_en = 1'b1;
        S_WAIT: begin
          bus.resp_val[owner_q] = bus.mul_resp_val;
          bus.mul_resp_rdy      = bus.resp_rdy[owner_q];
          bus.resp_msg          = bus.mul_resp_msg;
          resp_fire             = bus.mul_resp_val && bus.resp_rdy[owner_q];
          // Bypass re-arbitrates off the registered pointer, so the old owner
          // gets no priority on the overlapping grant.
          arb_en                = c_bypass && resp_fire;
        end
        default: ;
      endcase

      if (arb_en && any_val) begin
        bus.mul_req_val     = 1'b1;
        bus.mul_req_msg     = msg_arr[grant];
        bus.req_rdy[grant]  = bus.mul_req_rdy;
        req_fire            = bus.mul_req_rdy;
      end

      if (resp_fire) begin
        cnt_d   = cnt_q + 8'd1;
        state_d = S_IDLE;
      end

      if (req_fire) begin
        state_d = S_WAIT;
        owner_d = grant;
        ptr_d   = (32'(grant) == p_num_reqs - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner     = reset ? owner_q : '0;
  assign busy      = reset && (state_q == S_WAIT);
  assign num_xacts = reset ? cnt_q : '0;

endmodule

// File: tb/tb_imul_arbiter.sv
// Self-checking bench for imul_arbiter with three requesters. The bench plays
// both the requesters and a variable-latency multiplier, and compares every
// output each cycle against a cycle-level behavioural model of the arbiter.
module tb_imul_arbiter;

  localparam int N = 3;

`ifdef IMUL_ARBITER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] d_owner;
  logic       d_busy;
  logic [7:0] d_cnt;

  imul_arbiter_if #(.p_num_reqs(N), .p_msg_nbits(64), .p_resp_nbits(32)) bus ();

  imul_arbiter #(.p_num_reqs(N), .p_msg_nbits(64), .p_resp_nbits(32)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .owner    (d_owner),
    .busy     (d_busy),
    .num_xacts(d_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus
  logic [N-1:0] rv, rr;
  logic [63:0]  rm [N];
  bit           mstall;
  int           force_lat;
  // multiplier model
  bit           m_hold;
  int           m_lat;
  logic [31:0]  m_prod;
  // arbiter reference model
  bit           s_busy;
  int           s_ptr, s_owner, s_cnt;
  int           done_cnt;
  // observations
  int           cyc;
  int           obs_resp_cyc;
  logic [31:0]  obs_resp_msg;
  int           bp_first;
  int           glog[$];
  int           rlog[$];
  int           gaps[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Winner = valid requester with the smallest circular distance from the pointer.
  function automatic int pick(input logic [N-1:0] v, input int p);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic step();
    bit           rf, qf, can;
    int           g, go, nb;
    logic [N-1:0] e_rdy, e_rv;
    bus.req_val      = rv;
    for (int i = 0; i < N; i++) bus.req_msg[i*64 +: 64] = rm[i];
    bus.resp_rdy     = rr;
    bus.mul_req_rdy  = mstall ? 1'b0 : (!m_hold || m_lat == 0);
    bus.mul_resp_val = m_hold && m_lat == 0;
    bus.mul_resp_msg = (m_hold && m_lat == 0) ? m_prod : $urandom();
    rst_n            = rst_n;
    #2;
    if (!rst_n) begin
      chk("rst_busy", d_busy, 0);
      chk("rst_owner", d_owner, 0);
      chk("rst_cnt", d_cnt, 0);
      chk("rst_req_rdy", bus.req_rdy, 0);
      chk("rst_resp_val", bus.resp_val, 0);
      chk("rst_mul_req_val", bus.mul_req_val, 0);
      chk("rst_mul_resp_rdy", bus.mul_resp_rdy, 0);
      chk("rst_mul_req_msg", bus.mul_req_msg, 0);
      chk("rst_resp_msg", bus.resp_msg, 0);
      s_busy = 0; s_ptr = 0; s_owner = 0; s_cnt = 0; m_hold = 0;
    end else begin
      rf  = s_busy && bus.mul_resp_val && rr[s_owner];
      can = !s_busy || (BYP && rf);
      g   = pick(rv, s_ptr);
      qf  = can && (g >= 0) && bus.mul_req_rdy;
      e_rdy = '0;
      if (can && g >= 0) e_rdy[g] = bus.mul_req_rdy;
      e_rv = '0;
      if (s_busy) e_rv[s_owner] = bus.mul_resp_val;
      chk("busy", d_busy, s_busy);
      chk("owner", d_owner, s_owner);
      chk("num_xacts", d_cnt, s_cnt);
      chk("mul_req_val", bus.mul_req_val, can && (g >= 0));
      chk("req_rdy", bus.req_rdy, e_rdy);
      if (can && g >= 0) chk("mul_req_msg", bus.mul_req_msg, rm[g]);
      chk("resp_val", bus.resp_val, e_rv);
      chk("mul_resp_rdy", bus.mul_resp_rdy, s_busy ? rr[s_owner] : 1'b0);
      if (s_busy) chk("resp_msg", bus.resp_msg, bus.mul_resp_msg);
      // observed events from the DUT side of the handshakes
      if (d_busy && bus.mul_resp_val && bp_first < 0) bp_first = cyc;
      if (bus.mul_resp_val && bus.mul_resp_rdy) begin
        obs_resp_cyc = cyc;
        obs_resp_msg = bus.resp_msg;
        rlog.push_back(int'(d_owner));
      end
      if (bus.mul_req_val && bus.mul_req_rdy) begin
        go = -1; nb = 0;
        for (int i = 0; i < N; i++) if (bus.req_rdy[i]) begin go = i; nb++; end
        glog.push_back(nb == 1 ? go : -1);
        if (obs_resp_cyc >= 0) gaps.push_back(cyc - obs_resp_cyc);
        obs_resp_cyc = -1;
      end
      // advance the model and the multiplier
      if (rf) begin
        s_busy = 0;
        s_cnt  = (s_cnt + 1) % 256;
        m_hold = 0;
        done_cnt++;
      end
      if (qf) begin
        s_busy  = 1;
        s_owner = g;
        s_ptr   = (g + 1) % N;
        m_hold  = 1;
        m_prod  = rm[g][63:32] * rm[g][31:0];
        m_lat   = (force_lat >= 0) ? force_lat : int'($urandom_range(3, 0));
        rm[g]   = {$urandom(), $urandom()};
      end else if (m_hold && m_lat > 0) begin
        m_lat--;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = '0;
    step();
    step();
    rst_n = 1'b1;
    glog.delete(); rlog.delete(); gaps.delete();
    obs_resp_cyc = -1;
  endtask

  task automatic run_xacts(input int n);
    int start = done_cnt;
    for (int k = 0; k < 3000 && (done_cnt - start) < n; k++) step();
    chk("xact_budget", done_cnt - start, n);
  endtask

  initial begin
    rst_n = 1'b0; rv = '0; rr = '1; mstall = 0; force_lat = -1;
    m_hold = 0; m_lat = 0; m_prod = '0; done_cnt = 0; cyc = 0;
    s_busy = 0; s_ptr = 0; s_owner = 0; s_cnt = 0;
    obs_resp_cyc = -1; obs_resp_msg = '0; bp_first = -1;
    for (int i = 0; i < N; i++) rm[i] = {$urandom(), $urandom()};

    // 1. reset outputs, then a single {7,3} request from requester 0
    do_reset();
    rm[0] = {32'd7, 32'd3};
    rv = 3'b001; force_lat = 2;
    run_xacts(1);
    rv = '0;
    chk("single_glog_size", glog.size(), 1);
    chk("single_grant", glog[0], 0);
    chk("single_prod", obs_resp_msg, 32'd21);
    chk("single_cnt", d_cnt, 1);

    // 2. all three requesting: grant order 0,1,2,0
    do_reset();
    rv = 3'b111; force_lat = -1;
    run_xacts(4);
    rv = '0;
    chk("rr_glog_size", glog.size() >= 4, 1);
    chk("rr_grant0", glog[0], 0);
    chk("rr_grant1", glog[1], 1);
    chk("rr_grant2", glog[2], 2);
    chk("rr_grant3", glog[3], 0);
    chk("rr_owner0", rlog[0], 0);
    chk("rr_owner1", rlog[1], 1);
    chk("rr_owner2", rlog[2], 2);
    chk("rr_owner3", rlog[3], 0);
    for (int k = 0; k < 6; k++) step();

    // 3. backpressure: response held off for 5 cycles, fires on the 6th
    do_reset();
    force_lat = 0; rv = 3'b010;
    for (int k = 0; k < 10 && !s_busy; k++) step();
    chk("bp_started", s_busy, 1);
    rv = 3'b011; rr = 3'b101; bp_first = -1;
    for (int k = 0; k < 5; k++) step();
    chk("bp_still_busy", d_busy, 1);
    chk("bp_cnt_held", d_cnt, 0);
    rr = 3'b111;
    step();
    chk("bp_fire_cycle", obs_resp_cyc - bp_first + 1, 6);
    chk("bp_cnt", d_cnt, 1);
    rv = '0;
    for (int k = 0; k < 6; k++) step();

    // 4. reset in the middle of WAIT with owner=1 and three completed
    do_reset();
    force_lat = -1; rv = 3'b010;
    run_xacts(3);
    rr = 3'b000;
    for (int k = 0; k < 10 && !s_busy; k++) step();
    step();
    chk("mid_owner", d_owner, 1);
    chk("mid_cnt", d_cnt, 3);
    chk("mid_busy", d_busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rv = 3'b011; rr = 3'b111;
    #1;
    chk("post_rst_busy", d_busy, 0);
    chk("post_rst_owner", d_owner, 0);
    chk("post_rst_cnt", d_cnt, 0);
    glog.delete();
    run_xacts(1);
    chk("post_rst_first_grant", glog[0], 0);
    rv = '0;
    for (int k = 0; k < 6; k++) step();

    // 5. back-to-back gap with requesters 0 and 1 both valid
    do_reset();
    rv = 3'b011;
    run_xacts(6);
    rv = '0;
    chk("gap_count", gaps.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk("gap_len", gaps[i], BYP ? 0 : 1);
    for (int k = 0; k < 6; k++) step();

    // 6. counter wrap after 256 transactions
    do_reset();
    rv = 3'b001; force_lat = 0;
    run_xacts(255);
    chk("cnt_255", d_cnt, 255);
    run_xacts(1);
    chk("cnt_wrap", d_cnt, 0);
    rv = '0;
    for (int k = 0; k < 4; k++) step();

    // 7. random traffic with stalls and response backpressure
    do_reset();
    force_lat = -1;
    for (int k = 0; k < 400; k++) begin
      rv     = N'($urandom());
      rr     = N'($urandom()) | N'($urandom());
      mstall = ($urandom_range(3, 0) == 0);
      step();
    end
    mstall = 0; rv = '0; rr = '1;
    for (int k = 0; k < 10; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
